// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, ALU op codes and funct helpers for the instruction encoder.
package rv32i_pkg;

  typedef enum logic [1:0] {
    KIND_R    = 2'd0,
    KIND_I    = 2'd1,
    KIND_JAL  = 2'd2,
    KIND_JALR = 2'd3
  } kind_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [7:0] ALU_NONE = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_SLL  = 8'h03;
  localparam logic [7:0] ALU_SLT  = 8'h04;
  localparam logic [7:0] ALU_SLTU = 8'h05;
  localparam logic [7:0] ALU_XOR  = 8'h06;
  localparam logic [7:0] ALU_SRL  = 8'h07;
  localparam logic [7:0] ALU_SRA  = 8'h08;
  localparam logic [7:0] ALU_OR   = 8'h09;
  localparam logic [7:0] ALU_AND  = 8'h0a;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Unknown ops fall back to the add encoding.
  function automatic logic [2:0] alu_funct3(input logic [7:0] op);
    case (op)
      ALU_SLL:          return F3_SLL;
      ALU_SLT:          return F3_SLT;
      ALU_SLTU:         return F3_SLTU;
      ALU_XOR:          return F3_XOR;
      ALU_SRL, ALU_SRA: return F3_SRL_SRA;
      ALU_OR:           return F3_OR;
      ALU_AND:          return F3_AND;
      default:          return F3_ADD_SUB;
    endcase
  endfunction

  function automatic logic [6:0] alu_funct7(input logic [7:0] op);
    return ((op == ALU_SUB) || (op == ALU_SRA)) ? F7_ALT : F7_BASE;
  endfunction

  function automatic logic alu_known(input logic [7:0] op);
    return (op != ALU_NONE) && (op <= ALU_AND);
  endfunction

endpackage

// File: rtl/rv32i_insn_pack.sv
// Combinational packer: decoded fields to one RV32I word plus illegal flag.
// RV32I_ENCODER_CHECK_EN enables legality checking and NOP substitution.
module rv32i_insn_pack
  import rv32i_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [7:0]  op,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  kind_e       k;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic [31:0] raw;

  assign k = kind_e'(kind);

  always_comb begin
    f3       = alu_funct3(op);
    f7       = alu_funct7(op);
    is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    raw      = '0;
    case (k)
      KIND_R:    raw = {f7, ra2, ra1, f3, wa, OPC_OP};
      KIND_I:    raw = is_shift ? {f7, imm[4:0], ra1, f3, wa, OPC_OP_IMM}
                                : {imm[11:0], ra1, f3, wa, OPC_OP_IMM};
      KIND_JAL:  raw = {imm[20], imm[10:1], imm[11], imm[19:12], wa, OPC_JAL};
      KIND_JALR: raw = {imm[11:0], ra1, 3'b000, wa, OPC_JALR};
    endcase
  end

`ifdef RV32I_ENCODER_CHECK_EN
  logic               bad;
  logic signed [31:0] simm;

  assign simm = $signed(imm);

  always_comb begin
    bad = 1'b0;
    case (k)
      KIND_R:    bad = !alu_known(op);
      KIND_I:    bad = !alu_known(op) || (op == ALU_SUB) ||
                       (is_shift ? (imm > 32'd31) : ((simm < -2048) || (simm > 2047)));
      KIND_JAL:  bad = (simm < -1048576) || (simm > 1048574) || imm[0];
      KIND_JALR: bad = (simm < -2048) || (simm > 2047);
    endcase
  end

  assign illegal = bad;
  assign word    = bad ? NOP_WORD : raw;
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^imm[31:21];
  assign illegal       = 1'b0;
  assign word          = raw;
`endif

endmodule

// File: rtl/rv32i_encoder.sv
// Two-stage valid/ready RV32I encoder streaming words with byte addresses into instruction memory.
// RV32I_ENCODER_CHECK_EN (in rv32i_insn_pack) enables NOP substitution and error counting.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_kind,
  input  logic [7:0]               in_op,
  input  logic [4:0]               in_ra1,
  input  logic [4:0]               in_ra2,
  input  logic [4:0]               in_wa,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_word,
  output logic [$clog2(DEPTH)+1:0] out_addr,
  output logic                     out_err,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic [$clog2(DEPTH):0]   word_cnt
);

  localparam int unsigned AW = $clog2(DEPTH) + 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] WC_MAX = CW'(DEPTH);

  logic        s1_v;
  logic [1:0]  s1_kind;
  logic [7:0]  s1_op;
  logic [4:0]  s1_ra1, s1_ra2, s1_wa;
  logic [31:0] s1_imm;
  logic [31:0] pk_word;
  logic        pk_illegal;
  logic        s2_load, s1_ready, out_fire;

  assign s2_load  = !out_valid || out_ready;
  assign s1_ready = !s1_v || s2_load;
  assign in_ready = !rst && !clear && s1_ready;
  assign out_fire = out_valid && out_ready;

  // Stage 1 holds raw fields; packing happens on the way into stage 2.
  always_ff @(posedge clk) begin
    if (s1_ready && in_valid) begin
      s1_kind <= in_kind;
      s1_op   <= in_op;
      s1_ra1  <= in_ra1;
      s1_ra2  <= in_ra2;
      s1_wa   <= in_wa;
      s1_imm  <= in_imm;
    end
  end

  rv32i_insn_pack u_pack (
    .kind    (s1_kind),
    .op      (s1_op),
    .ra1     (s1_ra1),
    .ra2     (s1_ra2),
    .wa      (s1_wa),
    .imm     (s1_imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // out_addr tracks the address of the word at the head, so it advances only on delivery.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_err   <= 1'b0;
      out_addr  <= '0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      if (s1_ready) s1_v <= in_valid;
      if (s2_load) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_word <= pk_word;
          out_err  <= pk_illegal;
        end
      end
      if (out_fire) begin
        out_addr <= out_addr + AW'(4);
        if (word_cnt != WC_MAX) word_cnt <= word_cnt + CW'(1);
        if (out_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: directed vectors plus randomized traffic against a field-level model.
module tb_rv32i_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH) + 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef RV32I_ENCODER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]    in_kind;
  logic [7:0]    in_op;
  logic [4:0]    in_ra1, in_ra2, in_wa;
  logic [31:0]   in_imm, out_word;
  logic [AW-1:0] out_addr;
  logic [7:0]    err_cnt;
  logic [CW-1:0] word_cnt;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] nxt_word;
  logic        nxt_err;
  int unsigned m_addr, m_wcnt, m_ecnt;
  int          n_chk = 0, n_fail = 0;
  logic        last_in_fire, last_out_valid;

  always #5 clk = ~clk;

  rv32i_encoder #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_op(in_op), .in_ra1(in_ra1), .in_ra2(in_ra2),
    .in_wa(in_wa), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: builds the word by arithmetic on field positions.
  function automatic logic [32:0] ref_encode(input int kind, input int op, input int rs1,
                                             input int rs2, input int rd, input logic [31:0] imm);
    logic        known;
    int          opx, f3, f7, simm;
    logic [31:0] w;
    logic        e;
    known = (op >= 1) && (op <= 10);
    opx   = known ? op : 1;
    case (opx)
      3:       f3 = 1;
      4:       f3 = 2;
      5:       f3 = 3;
      6:       f3 = 4;
      7, 8:    f3 = 5;
      9:       f3 = 6;
      10:      f3 = 7;
      default: f3 = 0;
    endcase
    f7   = (opx == 2 || opx == 8) ? 32 : 0;
    simm = $signed(imm);
    e    = 1'b0;
    w    = '0;
    case (kind)
      0: begin
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        e = !known;
      end
      1: begin
        if (opx == 3 || opx == 7 || opx == 8) begin
          w = (((imm & 32'd31) | (f7 << 5)) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          e = imm > 32'd31;
        end else begin
          w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          e = (simm < -2048) || (simm > 2047);
        end
        e = e || !known || (op == 2);
      end
      2: begin
        w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        e = (simm < -(1 << 20)) || (simm > (1 << 20) - 2) || imm[0];
      end
      default: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
        e = (simm < -2048) || (simm > 2047);
      end
    endcase
    if (CHECK_EN && e) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // One cycle: inputs were driven at this negedge; evaluate, check, update model, move on.
  task automatic step();
    logic in_fire, out_fire;
    #1;
    in_fire        = in_valid && in_ready;
    out_fire       = out_valid && out_ready;
    last_in_fire   = in_fire;
    last_out_valid = out_valid;
    if (rst || clear) check("in_ready_flush", in_ready, 0);
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", out_valid, 0);
      else begin
        check("word", out_word, exp_q[0].word);
        check("err", out_err, exp_q[0].err);
        check("addr", out_addr, m_addr);
      end
    end
    check("word_cnt", word_cnt, m_wcnt);
    check("err_cnt", err_cnt, m_ecnt);
    if (rst || clear) begin
      exp_q.delete();
      m_addr = 0; m_wcnt = 0; m_ecnt = 0;
    end else begin
      if (out_fire && exp_q.size() > 0) begin
        if (exp_q[0].err && m_ecnt < 255) m_ecnt++;
        void'(exp_q.pop_front());
        m_addr = (m_addr + 4) % (DEPTH * 4);
        if (m_wcnt < DEPTH) m_wcnt++;
      end
      if (in_fire) exp_q.push_back('{word: nxt_word, err: nxt_err});
      check("occupancy", (exp_q.size() <= 2), 1);
    end
    @(negedge clk);
  endtask

  task automatic drive(input int k, input int op, input int ra1, input int ra2, input int wa,
                       input logic [31:0] imm);
    in_kind = k[1:0]; in_op = op[7:0]; in_ra1 = ra1[4:0]; in_ra2 = ra2[4:0];
    in_wa = wa[4:0]; in_imm = imm;
  endtask

  task automatic send(input int k, input int op, input int ra1, input int ra2, input int wa,
                      input logic [31:0] imm, input logic [31:0] ew, input logic ee);
    drive(k, op, ra1, ra2, wa, imm);
    nxt_word = ew; nxt_err = ee; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_in_fire) break;
    end
    if (!last_in_fire) check("accept_timeout", last_in_fire, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin
    int lat, idx;
    logic [32:0] r;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0);
    nxt_word = '0; nxt_err = 1'b0;
    m_addr = 0; m_wcnt = 0; m_ecnt = 0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_word", out_word, 0);
    check("rst_addr", out_addr, 0);
    check("rst_err", out_err, 0);

    // Directed encodings and latency with the sink always ready.
    out_ready = 1'b1;
    send(0, 1, 1, 2, 3, 32'd0, 32'h002081B3, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (last_out_valid) begin lat = i; break; end
    end
    check("latency", lat, 2);
    send(0, 2, 6, 7, 5, 32'd0, 32'h407302B3, 1'b0);
    send(1, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    send(1, 8, 2, 0, 2, 32'd3, 32'h40315113, 1'b0);
    send(2, 0, 0, 0, 1, 32'd8, 32'h008000EF, 1'b0);
    send(3, 0, 1, 0, 0, 32'd0, 32'h00008067, 1'b0);
    drain();

    // Illegal immediates/ops and range boundaries.
    send(1, 1, 0, 0, 0, 32'd2048, CHECK_EN ? 32'h13 : 32'h80000013, CHECK_EN);
    send(1, 2, 0, 0, 1, 32'd5, CHECK_EN ? 32'h13 : 32'h00500093, CHECK_EN);
    drain();
    check("err_cnt_illegal", err_cnt, CHECK_EN ? 2 : 0);
    send(2, 0, 0, 0, 0, 32'hFFF0_0000, 32'h8000006F, 1'b0);
    send(2, 0, 0, 0, 0, 32'd1048574, 32'h7FFFF06F, 1'b0);
    send(2, 0, 0, 0, 0, 32'd1048576, CHECK_EN ? 32'h13 : 32'h8000006F, CHECK_EN);
    send(1, 3, 0, 0, 0, 32'd32, CHECK_EN ? 32'h13 : 32'h00001013, CHECK_EN);
    drain();

    // Backpressure: three offered during a five-cycle stall, only two fit.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      r = ref_encode(1, 1, 0, 0, idx + 1, 32'(idx + 10));
      drive(1, 1, 0, 0, idx + 1, 32'(idx + 10));
      {nxt_err, nxt_word} = r;
      in_valid = (idx < 3);
      step();
      if (last_in_fire) idx++;
    end
    check("stall_accepted", idx, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      r = ref_encode(1, 1, 0, 0, idx + 1, 32'(idx + 10));
      drive(1, 1, 0, 0, idx + 1, 32'(idx + 10));
      {nxt_err, nxt_word} = r;
      in_valid = 1'b1;
      step();
      if (last_in_fire) idx++;
    end
    check("stall_all_taken", idx, 3);
    drain();

    // Clear mid-stall with an input offered: everything dropped, input refused.
    out_ready = 1'b0;
    send(0, 6, 1, 2, 3, 32'd0, 32'h0020C1B3, 1'b0);
    send(0, 9, 1, 2, 3, 32'd0, 32'h0020E1B3, 1'b0);
    clear = 1'b1; in_valid = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    step();
    check("clear_valid", out_valid, 0);
    check("clear_addr", out_addr, 0);
    check("clear_wcnt", word_cnt, 0);

    // Address wrap and word count saturation at DEPTH=4.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = ref_encode(1, 9, i, 0, i + 1, 32'(i * 3));
      send(1, 9, i, 0, i + 1, 32'(i * 3), r[31:0], r[32]);
    end
    drain();
    check("wrap_addr", out_addr, 4);
    check("wcnt_sat", word_cnt, DEPTH);

    // Randomized traffic with random backpressure and occasional clear.
    for (int c = 0; c < 400; c++) begin
      int k, op, ra1, ra2, wa;
      logic [31:0] imm;
      k = $urandom_range(0, 3); op = $urandom_range(0, 12);
      ra1 = $urandom_range(0, 31); ra2 = $urandom_range(0, 31); wa = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 40)) - 32'd8;
        1:       imm = $urandom();
        2:       imm = 32'($urandom_range(0, 4200)) - 32'd2100;
        default: imm = 32'($urandom_range(0, 1 << 22)) - 32'(1 << 21);
      endcase
      drive(k, op, ra1, ra2, wa, imm);
      {nxt_err, nxt_word} = ref_encode(k, op, ra1, ra2, wa, imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
